safe_vault_gen2: RTL and testbench
==================================

// Module: safe_vault_gen2
// PURPOSE
//  Clocked, parametrised successor of the safe-vault lock. An armed countdown window
//  accepts passcode entries on enter_psw edges and drives unlock or alarm.
//  Adds a configurable code width, timeout, retry limit and a remaining-tries output.
//  Sits between the keypad/debounce front end and the door actuator/siren drivers.
// PARAMETERS
//  CODE_W       16       passcode width in bits
//  DEFAULT_CODE 16'hE469 stored code after reset (CODE_W bits)
//  CLK_PER_SEC  50000000 clk cycles per countdown second (>=2)
//  TIMEOUT_S    5        countdown length in seconds (>=1); SEC_W=$clog2(TIMEOUT_S+1)
//  MAX_TRIES    3        wrong entries allowed before alarm (>=1); TRY_W=$clog2(MAX_TRIES+1)
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       asynchronous reset, active-high
//  ct_dn         in   1       level: arm countdown (1) / abort or relock (0)
//  enter_psw     in   1       level; a rising edge submits passcode
//  passcode      in   CODE_W  code under test, sampled on the enter_psw rising edge
//  unlock        out  1       vault open
//  alarm         out  1       alarm, sticky until reset
//  start         out  1       countdown running
//  sec           out  SEC_W   seconds remaining
//  tries_left    out  TRY_W   wrong entries still allowed
//  new_code/set_code in CODE_W/1  only with VAULT_CODE_CHANGE_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: outputs unlock=alarm=start=0, sec=0, tries_left=0.
//   Internal: state=IDLE, code register=DEFAULT_CODE, tick counter=0, enter_q=0.
//  Edge detect: enter_edge = enter_psw & ~enter_q. Registered decision: unlock/alarm/
//   tries_left change on the clock edge that samples enter_edge (one cycle after the rise).
//  FSM states: IDLE, COUNTDOWN, UNLOCKED, ALARM (enum in package).
//  IDLE: ct_dn=1 -> COUNTDOWN; load sec=TIMEOUT_S and tries_left=MAX_TRIES; clear tick counter.
//  COUNTDOWN (start=1):
//   - tick: counter counts 0..CLK_PER_SEC-1; a one-cycle tick fires at the terminal count.
//     Each tick decrements sec. The first second is full length.
//   - enter_edge with passcode==code -> UNLOCKED; sec frozen.
//   - enter_edge with a mismatch -> tries_left-1. If the result is 0 -> ALARM.
//   - tick with sec==1 and no correct entry -> sec=0, ALARM.
//   - ct_dn=0 -> IDLE; sec and tries_left cleared. Abort has priority over a tick.
//  Priority on the same clock edge: reset > correct entry > ct_dn abort > wrong entry/timeout.
//   A correct entry on the final tick unlocks with no alarm.
//  UNLOCKED (unlock=1, start=0): ct_dn=0 -> IDLE (relock). enter_psw ignored.
//  ALARM (alarm=1, start=0, unlock=0): sticky; exits only via reset. Inputs ignored.
//  Reset mid-operation: all outputs return to reset values immediately (async);
//   code register reverts to DEFAULT_CODE.
//  Compare is a full CODE_W equality; sec and tries_left never wrap below 0.
// CONFIGURATION
//  VAULT_CODE_CHANGE_EN defined:
//   - adds ports new_code[CODE_W] and set_code.
//   - set_code=1 while in UNLOCKED loads code<=new_code on that clock edge.
//   - set_code is ignored in any other state.
//  Undefined: ports absent; code register is constant DEFAULT_CODE.
// STRUCTURE
//  vault_pkg: vault_state_e enum; SEC_W and TRY_W helper functions ($clog2 wrappers).
//  Sub-module vault_sec_tick:
//   - parameter CLK_PER_SEC; ports clk, reset, clr, en, tick.
//   - counter cleared on clr or reset.
//  Top: FSM, edge detect, code register, sec and tries counters.
// TESTING (CLK_PER_SEC=4, TIMEOUT_S=5, MAX_TRIES=3, DEFAULT_CODE=16'hE469)
//  1. Correct entry: reset, ct_dn=1, passcode=E469, enter_psw rises at cycle 9
//     -> unlock=1 at cycle 10, sec=3, alarm=0.
//  2. Wrong entries: ct_dn=1, three enter edges with E479
//     -> tries_left 3->2->1->0, alarm=1 after the 3rd edge, unlock=0.
//  3. Timeout: ct_dn=1, no entry -> sec 5,4,3,2,1,0 every 4 cycles; alarm=1 at cycle 20.
//  4. Mid-reset: reset asserted asynchronously during COUNTDOWN with sec=2
//     -> outputs clear before the next clk edge; re-arm gives sec=5.
//  5. Race: correct E469 edge on the same edge as the final tick
//     -> unlock=1, alarm stays 0; ct_dn=0 then returns to IDLE.
//  6. With VAULT_CODE_CHANGE_EN: unlocked, set_code with new_code=16'h1234, relock, re-arm
//     -> E469 decrements tries; 1234 unlocks.

Source files
------------

// File: rtl/vault_pkg.sv
// Shared types and width helpers for the safe vault.
package vault_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNTDOWN,
    UNLOCKED,
    ALARM
  } vault_state_e;

  function automatic int sec_w(input int timeout_s);
    return $clog2(timeout_s + 1);
  endfunction

  function automatic int try_w(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

endpackage

// File: rtl/vault_sec_tick.sv
// One-second tick generator for the vault countdown.
module vault_sec_tick #(
  parameter int CLK_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_PER_SEC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/safe_vault_gen2.sv
// Safe vault lock: armed countdown, passcode entry, unlock or sticky alarm.
// Optional runtime code change is enabled with VAULT_CODE_CHANGE_EN.
module safe_vault_gen2
  import vault_pkg::*;
#(
  parameter int                CODE_W       = 16,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = 16'hE469,
  parameter int                CLK_PER_SEC  = 50000000,
  parameter int                TIMEOUT_S    = 5,
  parameter int                MAX_TRIES    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ct_dn,
  input  logic                           enter_psw,
  input  logic [CODE_W-1:0]              passcode,
`ifdef VAULT_CODE_CHANGE_EN
  input  logic [CODE_W-1:0]              new_code,
  input  logic                           set_code,
`endif
  output logic                           unlock,
  output logic                           alarm,
  output logic                           start,
  output logic [sec_w(TIMEOUT_S)-1:0]    sec,
  output logic [try_w(MAX_TRIES)-1:0]    tries_left
);

  localparam int SEC_W = sec_w(TIMEOUT_S);
  localparam int TRY_W = try_w(MAX_TRIES);

  vault_state_e      state;
  vault_state_e      state_n;
  logic [SEC_W-1:0]  sec_n;
  logic [TRY_W-1:0]  tries_n;
  logic [CODE_W-1:0] code;
  logic              enter_q;
  logic              enter_edge;
  logic              match;
  logic              tick;

  assign enter_edge = enter_psw & ~enter_q;
  assign match      = (passcode == code);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) enter_q <= 1'b0;
    else       enter_q <= enter_psw;
  end

`ifdef VAULT_CODE_CHANGE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code <= DEFAULT_CODE;
    end else if (state == UNLOCKED && set_code) begin
      code <= new_code;
    end
  end
`else
  assign code = DEFAULT_CODE;
`endif

  vault_sec_tick #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state != COUNTDOWN),
    .en   (state == COUNTDOWN),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sec        <= '0;
      tries_left <= '0;
    end else begin
      state      <= state_n;
      sec        <= sec_n;
      tries_left <= tries_n;
    end
  end

  always_comb begin
    state_n = state;
    sec_n   = sec;
    tries_n = tries_left;
    unique case (state)
      IDLE: begin
        if (ct_dn) begin
          state_n = COUNTDOWN;
          sec_n   = SEC_W'(TIMEOUT_S);
          tries_n = TRY_W'(MAX_TRIES);
        end
      end
      COUNTDOWN: begin
        // Correct entry beats abort, which beats wrong entry and timeout.
        if (enter_edge && match) begin
          state_n = UNLOCKED;
        end else if (!ct_dn) begin
          state_n = IDLE;
          sec_n   = '0;
          tries_n = '0;
        end else begin
          if (enter_edge && tries_left != '0) begin
            tries_n = tries_left - 1'b1;
            if (tries_left == TRY_W'(1)) state_n = ALARM;
          end
          if (tick && sec != '0) begin
            sec_n = sec - 1'b1;
            if (sec == SEC_W'(1)) state_n = ALARM;
          end
        end
      end
      UNLOCKED: begin
        if (!ct_dn) begin
          state_n = IDLE;
          sec_n   = '0;
          tries_n = '0;
        end
      end
      ALARM: begin
        state_n = ALARM;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign unlock = (state == UNLOCKED);
  assign alarm  = (state == ALARM);
  assign start  = (state == COUNTDOWN);

endmodule

// File: tb/tb_safe_vault_gen2.sv
// Directed self-checking bench for safe_vault_gen2.
module tb_safe_vault_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ct_dn;
  logic        enter_psw;
  logic [15:0] passcode;
`ifdef VAULT_CODE_CHANGE_EN
  logic [15:0] new_code;
  logic        set_code;
`endif
  logic        unlock;
  logic        alarm;
  logic        start;
  logic [2:0]  sec;
  logic [1:0]  tries_left;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  safe_vault_gen2 #(
    .CODE_W      (16),
    .DEFAULT_CODE(16'hE469),
    .CLK_PER_SEC (4),
    .TIMEOUT_S   (5),
    .MAX_TRIES   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ct_dn     (ct_dn),
    .enter_psw (enter_psw),
    .passcode  (passcode),
`ifdef VAULT_CODE_CHANGE_EN
    .new_code  (new_code),
    .set_code  (set_code),
`endif
    .unlock    (unlock),
    .alarm     (alarm),
    .start     (start),
    .sec       (sec),
    .tries_left(tries_left)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, then arm so that the arming edge is "edge 0"; returns at edge0+1.
  task automatic reset_and_arm();
    reset     = 1'b1;
    ct_dn     = 1'b0;
    enter_psw = 1'b0;
    passcode  = 16'h0000;
`ifdef VAULT_CODE_CHANGE_EN
    set_code  = 1'b0;
    new_code  = 16'h0000;
`endif
    step(2);
    reset = 1'b0;
    ct_dn = 1'b1;
    step(1);
  endtask

  task automatic pulse_enter(input logic [15:0] code);
    passcode  = code;
    enter_psw = 1'b1;
    step(1);
    enter_psw = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ct_dn     = 1'b1;
    enter_psw = 1'b0;
    passcode  = 16'hE469;
`ifdef VAULT_CODE_CHANGE_EN
    set_code  = 1'b0;
    new_code  = 16'h0000;
`endif
    step(2);
    checks++;
    if ({unlock, alarm, start, sec, tries_left} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got u=%b a=%b s=%b sec=%0d tries=%0d exp all 0",
               unlock, alarm, start, sec, tries_left);
    end
    reset = 1'b0;
    ct_dn = 1'b0;
    step(1);
  endtask

  task automatic test_correct_entry();
    reset_and_arm();
    checks++;
    if ({start, sec, tries_left} !== {1'b1, 3'd5, 2'd3}) begin
      failures++;
      $display("FAIL arm_load: got start=%b sec=%0d tries=%0d exp 1/5/3",
               start, sec, tries_left);
    end
    step(9);
    passcode  = 16'hE469;
    enter_psw = 1'b1;
    step(1);
    checks++;
    if ({unlock, alarm, start, sec} !== {3'b100, 3'd3}) begin
      failures++;
      $display("FAIL correct_unlock: got u=%b a=%b s=%b sec=%0d exp 1/0/0/3",
               unlock, alarm, start, sec);
    end
    step(3);
    checks++;
    if ({unlock, sec} !== {1'b1, 3'd3}) begin
      failures++;
      $display("FAIL sec_frozen: got u=%b sec=%0d exp 1/3", unlock, sec);
    end
    enter_psw = 1'b0;
    ct_dn     = 1'b0;
    step(1);
    checks++;
    if ({unlock, alarm, start} !== 3'b000) begin
      failures++;
      $display("FAIL relock: got u=%b a=%b s=%b exp 000", unlock, alarm, start);
    end
  endtask

  task automatic test_wrong_entries();
    reset_and_arm();
    passcode  = 16'hE479;
    enter_psw = 1'b1;
    step(3);
    checks++;
    if (tries_left !== 2'd2) begin
      failures++;
      $display("FAIL held_level_once: got tries=%0d exp 2", tries_left);
    end
    enter_psw = 1'b0;
    step(1);
    enter_psw = 1'b1;
    step(1);
    checks++;
    if ({tries_left, alarm} !== {2'd1, 1'b0}) begin
      failures++;
      $display("FAIL wrong_2: got tries=%0d a=%b exp 1/0", tries_left, alarm);
    end
    enter_psw = 1'b0;
    step(1);
    enter_psw = 1'b1;
    step(1);
    checks++;
    if ({tries_left, unlock, alarm, start, sec} !== {2'd0, 3'b010, 3'd4}) begin
      failures++;
      $display("FAIL wrong_3_alarm: got tries=%0d u=%b a=%b s=%b sec=%0d exp 0/0/1/0/4",
               tries_left, unlock, alarm, start, sec);
    end
    enter_psw = 1'b0;
    ct_dn     = 1'b0;
    step(2);
    pulse_enter(16'hE469);
    checks++;
    if ({unlock, alarm, tries_left} !== {2'b01, 2'd0}) begin
      failures++;
      $display("FAIL alarm_sticky: got u=%b a=%b tries=%0d exp 0/1/0",
               unlock, alarm, tries_left);
    end
  endtask

  task automatic test_timeout();
    reset_and_arm();
    for (int k = 1; k <= 5; k++) begin
      step(3);
      checks++;
      if ({sec, alarm} !== {3'(6 - k), 1'b0}) begin
        failures++;
        $display("FAIL timeout_pre_%0d: got sec=%0d a=%b exp %0d/0", k, sec, alarm, 6 - k);
      end
      step(1);
      checks++;
      if ({sec, alarm} !== {3'(5 - k), (k == 5)}) begin
        failures++;
        $display("FAIL timeout_tick_%0d: got sec=%0d a=%b exp %0d/%0d",
                 k, sec, alarm, 5 - k, (k == 5));
      end
    end
  endtask

  task automatic test_abort();
    reset_and_arm();
    step(3);
    ct_dn = 1'b0;
    step(1);
    checks++;
    if ({start, alarm, unlock, sec, tries_left} !== 8'h00) begin
      failures++;
      $display("FAIL abort_over_tick: got s=%b a=%b u=%b sec=%0d tries=%0d exp all 0",
               start, alarm, unlock, sec, tries_left);
    end
  endtask

  task automatic test_mid_reset();
    reset_and_arm();
    step(13);
    checks++;
    if (sec !== 3'd2) begin
      failures++;
      $display("FAIL mid_pre_sec: got sec=%0d exp 2", sec);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({unlock, alarm, start, sec, tries_left} !== 8'h00) begin
      failures++;
      $display("FAIL mid_async_clear: got u=%b a=%b s=%b sec=%0d tries=%0d exp all 0",
               unlock, alarm, start, sec, tries_left);
    end
    step(1);
    reset = 1'b0;
    step(1);
    checks++;
    if ({start, sec, tries_left} !== {1'b1, 3'd5, 2'd3}) begin
      failures++;
      $display("FAIL mid_rearm: got s=%b sec=%0d tries=%0d exp 1/5/3",
               start, sec, tries_left);
    end
  endtask

  task automatic test_race();
    reset_and_arm();
    step(19);
    checks++;
    if ({sec, start} !== {3'd1, 1'b1}) begin
      failures++;
      $display("FAIL race_pre: got sec=%0d s=%b exp 1/1", sec, start);
    end
    passcode  = 16'hE469;
    enter_psw = 1'b1;
    step(1);
    checks++;
    if ({unlock, alarm, start, sec} !== {3'b100, 3'd1}) begin
      failures++;
      $display("FAIL race_unlock: got u=%b a=%b s=%b sec=%0d exp 1/0/0/1",
               unlock, alarm, start, sec);
    end
    enter_psw = 1'b0;
    ct_dn     = 1'b0;
    step(1);
    checks++;
    if ({unlock, alarm, start} !== 3'b000) begin
      failures++;
      $display("FAIL race_relock: got u=%b a=%b s=%b exp 000", unlock, alarm, start);
    end
  endtask

`ifdef VAULT_CODE_CHANGE_EN
  task automatic test_code_change();
    reset_and_arm();
    new_code = 16'h1234;
    set_code = 1'b1;
    step(1);
    set_code = 1'b0;
    pulse_enter(16'hE469);
    set_code = 1'b1;
    step(1);
    set_code = 1'b0;
    ct_dn    = 1'b0;
    step(1);
    ct_dn = 1'b1;
    step(1);
    pulse_enter(16'hE469);
    checks++;
    if ({unlock, tries_left} !== {1'b0, 2'd2}) begin
      failures++;
      $display("FAIL old_code_rejected: got u=%b tries=%0d exp 0/2", unlock, tries_left);
    end
    pulse_enter(16'h1234);
    checks++;
    if ({unlock, alarm} !== 2'b10) begin
      failures++;
      $display("FAIL new_code_unlocks: got u=%b a=%b exp 1/0", unlock, alarm);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_correct_entry();
    test_wrong_entries();
    test_timeout();
    test_abort();
    test_mid_reset();
    test_race();
`ifdef VAULT_CODE_CHANGE_EN
    test_code_change();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
